// File: rtl/isp_pkg.sv
// Shared ISP constants: default raster geometry and RGB565 colours.
package isp_pkg;

   localparam int ISP_H_ACT = 640;
   localparam int ISP_V_ACT = 480;

   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_RED   = 16'hF800;

endpackage

// File: rtl/isp_frame_xy_cnt.sv
// Raster x/y position tracker advanced by pixel valid, with frame_start clear and
// a combinational frame_end flag on the last active pixel.
module isp_frame_xy_cnt #(
   parameter int H_ACT = 640,
   parameter int V_ACT = 480,
   parameter int XW    = $clog2(H_ACT),
   parameter int YW    = $clog2(V_ACT)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          frame_start,
   input  logic          wr_en,
   output logic [XW-1:0] cur_x,
   output logic [YW-1:0] cur_y,
   output logic          frame_end
);

   localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;

   // frame_start takes effect in the same cycle, so a coincident pixel sits at (0,0)
   assign cur_x     = frame_start ? '0 : x_cnt;
   assign cur_y     = frame_start ? '0 : y_cnt;
   assign frame_end = wr_en && (cur_x == X_LAST) && (cur_y == Y_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (wr_en) begin
         if (cur_x == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
         end else begin
            x_cnt <= cur_x + XW'(1);
            y_cnt <= cur_y;
         end
      end else if (frame_start) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end
   end

endmodule

// File: rtl/isp_1bit_bbox_detect.sv
// Bounding-box detector for the eroded 1-bit stream: per-frame box and pixel count,
// latched at frame end, and an RGB565 re-emit with the previous frame's box outlined.
module isp_1bit_bbox_detect
   import isp_pkg::*;
#(
   parameter int          H_ACT      = ISP_H_ACT,
   parameter int          V_ACT      = ISP_V_ACT,
   parameter int          MIN_PIXELS = 16,
   parameter logic [15:0] BOX_COLOR  = RGB565_RED,
   parameter int          XW         = $clog2(H_ACT),
   parameter int          YW         = $clog2(V_ACT),
   parameter int          CW         = $clog2(H_ACT * V_ACT + 1)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          frame_start,
   input  logic          wr_en,
   input  logic          img_1bit_in,
   output logic          bbox_wr_en,
   output logic [15:0]   bbox_rgb565,
   output logic [XW-1:0] box_x_min,
   output logic [XW-1:0] box_x_max,
   output logic [YW-1:0] box_y_min,
   output logic [YW-1:0] box_y_max,
   output logic [CW-1:0] obj_pixel_cnt,
   output logic          box_found,
   output logic          box_valid
);

   localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic          frame_end;

   isp_frame_xy_cnt #(
      .H_ACT (H_ACT),
      .V_ACT (V_ACT),
      .XW    (XW),
      .YW    (YW)
   ) u_xy_cnt (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .cur_x       (cur_x),
      .cur_y       (cur_y),
      .frame_end   (frame_end)
   );

   logic [XW-1:0] run_x_min, run_x_max, nxt_x_min, nxt_x_max;
   logic [YW-1:0] run_y_min, run_y_max, nxt_y_min, nxt_y_max;
   logic [CW-1:0] run_cnt, nxt_cnt;

   // Running box including the current pixel; frame_start discards the partial frame first
   always_comb begin
      nxt_x_min = frame_start ? X_LAST : run_x_min;
      nxt_x_max = frame_start ? '0     : run_x_max;
      nxt_y_min = frame_start ? Y_LAST : run_y_min;
      nxt_y_max = frame_start ? '0     : run_y_max;
      nxt_cnt   = frame_start ? '0     : run_cnt;
      if (wr_en && img_1bit_in) begin
         if (cur_x < nxt_x_min) nxt_x_min = cur_x;
         if (cur_x > nxt_x_max) nxt_x_max = cur_x;
         if (cur_y < nxt_y_min) nxt_y_min = cur_y;
         if (cur_y > nxt_y_max) nxt_y_max = cur_y;
         nxt_cnt = nxt_cnt + CW'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_x_min     <= X_LAST;
         run_x_max     <= '0;
         run_y_min     <= Y_LAST;
         run_y_max     <= '0;
         run_cnt       <= '0;
         box_x_min     <= '0;
         box_x_max     <= '0;
         box_y_min     <= '0;
         box_y_max     <= '0;
         obj_pixel_cnt <= '0;
         box_found     <= 1'b0;
         box_valid     <= 1'b0;
      end else if (frame_end) begin
         run_x_min     <= X_LAST;
         run_x_max     <= '0;
         run_y_min     <= Y_LAST;
         run_y_max     <= '0;
         run_cnt       <= '0;
         box_x_min     <= nxt_x_min;
         box_x_max     <= nxt_x_max;
         box_y_min     <= nxt_y_min;
         box_y_max     <= nxt_y_max;
         obj_pixel_cnt <= nxt_cnt;
         box_found     <= (nxt_cnt >= CW'(MIN_PIXELS));
         box_valid     <= 1'b1;
      end else begin
         run_x_min     <= nxt_x_min;
         run_x_max     <= nxt_x_max;
         run_y_min     <= nxt_y_min;
         run_y_max     <= nxt_y_max;
         run_cnt       <= nxt_cnt;
         box_valid     <= 1'b0;
      end
   end

   logic on_col, on_row, edge_hit;

   // Outline uses the box latched before this edge, i.e. the previous frame's result
   always_comb begin
      on_col   = ((cur_x == box_x_min) || (cur_x == box_x_max)) &&
                 (cur_y >= box_y_min) && (cur_y <= box_y_max);
      on_row   = ((cur_y == box_y_min) || (cur_y == box_y_max)) &&
                 (cur_x >= box_x_min) && (cur_x <= box_x_max);
      edge_hit = box_found && (on_col || on_row);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bbox_wr_en  <= 1'b0;
         bbox_rgb565 <= RGB565_BLACK;
      end else begin
         bbox_wr_en  <= wr_en;
         if (!wr_en)
            bbox_rgb565 <= RGB565_BLACK;
         else if (edge_hit)
            bbox_rgb565 <= BOX_COLOR;
         else
            bbox_rgb565 <= img_1bit_in ? RGB565_WHITE : RGB565_BLACK;
      end
   end

endmodule
